// File: rtl/hazard_unit_if.sv
// Pipeline control bundle between controller/datapath (master) and hazard unit (slave).
// Carries per-stage register numbers and control bits in, forwarding/stall controls out.
interface hazard_unit_if;
    logic [4:0] rsD, rtD, rsE, rtE;
    logic [4:0] writeregE, writeregM, writeregW;
    logic       regwriteE, regwriteM, regwriteW;
    logic       memtoregE, memtoregM;
    logic       branchD, bneD;
    logic       mdstartE, mdneedD;
    logic       forwardaD, forwardbD;
    logic [1:0] forwardaE, forwardbE;
    logic       stallF, stallD, flushE;
    logic       mdbusy, mddone;

    modport master (
        output rsD, rtD, rsE, rtE, writeregE, writeregM, writeregW,
        output regwriteE, regwriteM, regwriteW, memtoregE, memtoregM,
        output branchD, bneD, mdstartE, mdneedD,
        input  forwardaD, forwardbD, forwardaE, forwardbE,
        input  stallF, stallD, flushE, mdbusy, mddone
    );

    modport slave (
        input  rsD, rtD, rsE, rtE, writeregE, writeregM, writeregW,
        input  regwriteE, regwriteM, regwriteW, memtoregE, memtoregM,
        input  branchD, bneD, mdstartE, mdneedD,
        output forwardaD, forwardbD, forwardaE, forwardbE,
        output stallF, stallD, flushE, mdbusy, mddone
    );
endinterface

// File: rtl/hazard_unit.sv
// Forwarding selects, load-use/branch/mult-div stalls and E flush for a 5-stage pipeline.
// Also tracks occupancy of the multi-cycle mult/div unit.
module hazard_unit #(
    parameter int unsigned MD_LATENCY = 32
) (
    input logic          clk,
    input logic          reset,
    hazard_unit_if.slave hz
);
    localparam logic [5:0] LatCnt = 6'(MD_LATENCY);

    typedef enum logic [0:0] {StIdle, StBusy} md_state_e;

    md_state_e  state;
    logic [5:0] cnt;
    logic       mdbusy, mddone;
    logic [1:0] fwd_a_e, fwd_b_e;
    logic       fwd_a_d, fwd_b_d;
    logic       lwstall, brstall, mdstall, stall;

    // Register 0 is hardwired to zero, so it never forwards or interlocks.
    function automatic logic hit(input logic [4:0] src, input logic [4:0] dst);
        return (src != 5'd0) && (src == dst);
    endfunction

    always_comb begin
        fwd_a_e = 2'b00;
        if (hz.regwriteM && hit(hz.rsE, hz.writeregM))      fwd_a_e = 2'b10;
        else if (hz.regwriteW && hit(hz.rsE, hz.writeregW)) fwd_a_e = 2'b01;

        fwd_b_e = 2'b00;
        if (hz.regwriteM && hit(hz.rtE, hz.writeregM))      fwd_b_e = 2'b10;
        else if (hz.regwriteW && hit(hz.rtE, hz.writeregW)) fwd_b_e = 2'b01;

        fwd_a_d = hz.regwriteM && hit(hz.rsD, hz.writeregM);
        fwd_b_d = hz.regwriteM && hit(hz.rtD, hz.writeregM);

        lwstall = hz.memtoregE && hz.regwriteE &&
                  (hit(hz.rsD, hz.writeregE) || hit(hz.rtD, hz.writeregE));
        brstall = (hz.branchD || hz.bneD) &&
                  ((hz.regwriteE && (hit(hz.rsD, hz.writeregE) || hit(hz.rtD, hz.writeregE))) ||
                   (hz.memtoregM && (hit(hz.rsD, hz.writeregM) || hit(hz.rtD, hz.writeregM))));
        mdstall = hz.mdneedD && (mdbusy || hz.mdstartE);
        stall   = lwstall || brstall || mdstall;
    end

    // A start while busy is ignored; D-stage interlock keeps a legal pipeline from issuing one.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state  <= StIdle;
            cnt    <= 6'd0;
            mdbusy <= 1'b0;
            mddone <= 1'b0;
        end else begin
            mddone <= 1'b0;
            unique case (state)
                StIdle: begin
                    if (hz.mdstartE) begin
                        state  <= StBusy;
                        cnt    <= LatCnt;
                        mdbusy <= 1'b1;
                    end
                end
                StBusy: begin
                    if (cnt == 6'd1) begin
                        state  <= StIdle;
                        cnt    <= 6'd0;
                        mdbusy <= 1'b0;
                        mddone <= 1'b1;
                    end else begin
                        cnt <= cnt - 6'd1;
                    end
                end
                default: begin
                    state  <= StIdle;
                    cnt    <= 6'd0;
                    mdbusy <= 1'b0;
                end
            endcase
        end
    end

    assign hz.forwardaE = fwd_a_e;
    assign hz.forwardbE = fwd_b_e;
    assign hz.forwardaD = fwd_a_d;
    assign hz.forwardbD = fwd_b_d;
    assign hz.stallF    = stall;
    assign hz.stallD    = stall;
    assign hz.flushE    = stall;
    assign hz.mdbusy    = mdbusy;
    assign hz.mddone    = mddone;
endmodule
